touch_pulse_gen: RTL
====================

Name: touch_pulse_gen

Overview:
- Upstream front-end for the scoring counter.
- Takes the raw, asynchronous touch-sensor/button level, synchronizes and debounces it, and emits exactly one single-cycle `touch` pulse per qualified press.
- Enforces a minimum interval between scoring events (lockout).
- `touch` drives the increase input of the least-significant BCD digit counter directly.

Parameters:
- DEB_CYCLES, 1000000, consecutive stable synchronized cycles required to accept a level change (10 ms at 100 MHz).
- LOCKOUT_CYCLES, 10000000, cycles after an emitted pulse during which no new pulse may be emitted (100 ms).
- REPEAT_CYCLES, 50000000, auto-repeat period while held (used only with the optional feature).
- CNT_W, 26, width of the internal counters; must hold max(DEB_CYCLES, LOCKOUT_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = pulses permitted; 0 = pulses suppressed while tracking continues.
- sensor_in  input  1  raw sensor level, asynchronous, active-high.
- touch  output  1  single-cycle scoring pulse; feeds the counter's increase input.
- pressed  output  1  debounced sensor level.
- busy  output  1  high while the lockout counter is nonzero.

Behaviour:
- Reset (async assert, sync release):
  - sync flops = 0, FSM = IDLE, debounce counter = 0, lockout counter = 0.
  - touch = 0, pressed = 0, busy = 0.
  - Reset mid-press or mid-lockout discards everything; no pulse is produced during or immediately after reset.
- Synchronizer: two flops, s1 <= sensor_in, s0 <= s1. Only s0 is used downstream.
- FSM states and transitions:
  - IDLE: pressed = 0. s0 = 1 -> ARM, debounce counter cleared.
  - ARM: counter increments while s0 = 1. s0 = 0 -> IDLE (bounce rejected, counter cleared). Counter == DEB_CYCLES-1 with s0 = 1 -> HELD.
  - HELD: pressed = 1. s0 = 0 -> REL, counter cleared.
  - REL: counter increments while s0 = 0. s0 = 1 -> HELD (bounce rejected). Counter == DEB_CYCLES-1 with s0 = 0 -> IDLE.
- Pulse rule:
  - touch is registered and is 1 for exactly one cycle, in the cycle after the ARM->HELD transition.
  - Requires enable = 1 and lockout counter = 0 at the transition cycle.
- Latency: with sensor_in sampled high from edge t onward and held stable, touch is high in cycle t+2+DEB_CYCLES.
- Lockout:
  - On the edge that sets touch, the lockout counter loads LOCKOUT_CYCLES.
  - Otherwise it decrements by 1 per cycle, saturating at 0.
  - busy = (lockout != 0), registered.
- Dropped presses: a qualified press while busy = 1 or enable = 0 still sets pressed, but no pulse is emitted. It is not queued and not emitted later.
- No pulses on release or from REL bounces.
- At most one pulse per press, independent of how long the press is held (absent the optional feature).
- enable toggling has no effect on FSM or lockout progress; it gates pulse emission only.
- Counters never wrap: the debounce counter is cleared on every state change; the lockout counter saturates at 0.

Optional Feature:
- Macro: TOUCH_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter counts cycles from HELD entry.
  - Each time it reaches REPEAT_CYCLES-1, it clears and touch pulses for one cycle, subject to enable = 1 and lockout = 0. Each such pulse reloads lockout.
  - A repeat that lands during lockout is dropped; the counter still clears.
  - The repeat counter is cleared on leaving HELD.
- Not defined: no repeat counter is present; exactly one pulse per press.

Test Plan (DEB_CYCLES=4, LOCKOUT_CYCLES=10, REPEAT_CYCLES=8, CNT_W=8):
- Reset, then sensor_in high at edge 5 and held -> touch = 1 only at cycle 11; pressed = 1 from cycle 11; busy = 1 for cycles 12-21.
- sensor_in high for 3 cycles then low for 2, repeated 5 times -> touch never asserts; pressed stays 0.
- Clean press (6 cycles high), release, second clean press qualifying 5 cycles after the first pulse -> the second press produces no pulse (inside lockout). Third press qualifying after busy falls -> one pulse.
- Press held 40 cycles with macro undefined -> exactly 1 touch pulse. With TOUCH_AUTOREPEAT_EN defined -> pulses at entry, then at repeats where lockout = 0 (entry+16, entry+32).
- enable = 0 during a qualified press -> pressed = 1, touch = 0, busy stays 0. Re-press with enable = 1 -> one pulse.
- rst_n asserted in ARM with counter at 2, released, sensor_in held high -> all outputs 0 during reset; pulse occurs DEB_CYCLES+2 cycles after release, not earlier.

Source files
------------

// File: rtl/touch_pulse_gen.sv
// Touch front-end: synchronizes and debounces a raw sensor level and emits one scoring pulse
// per qualified press, followed by a lockout window. Optional auto-repeat: TOUCH_AUTOREPEAT_EN.
module touch_pulse_gen #(
  parameter int unsigned DEB_CYCLES     = 1000000,
  parameter int unsigned LOCKOUT_CYCLES = 10000000,
  parameter int unsigned REPEAT_CYCLES  = 50000000,
  parameter int unsigned CNT_W          = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic sensor_in,
  output logic touch,
  output logic pressed,
  output logic busy
);

  localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LockLoad = CNT_W'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StArm, StHeld, StRel} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s0_q;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] lock_q, lock_d;
  logic             touch_q, touch_d;
  logic             pressed_q, pressed_d;
  logic             busy_q, busy_d;
  logic             fire;
  logic             rep_fire;

  // Two-flop synchronizer; only s0_q is used past this point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s0_q <= 1'b0;
    end else begin
      s1_q <= sensor_in;
      s0_q <= s1_q;
    end
  end

  // Debounce FSM; the counter is cleared on every state change so it never wraps.
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    fire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s0_q) begin
          state_d = StArm;
          deb_d   = '0;
        end
      end
      StArm: begin
        if (!s0_q) begin
          state_d = StIdle;
          deb_d   = '0;
        end else if (deb_q == DebLast) begin
          state_d = StHeld;
          deb_d   = '0;
          fire    = 1'b1;
        end else begin
          deb_d = deb_q + CNT_W'(1);
        end
      end
      StHeld: begin
        if (!s0_q) begin
          state_d = StRel;
          deb_d   = '0;
        end
      end
      StRel: begin
        if (s0_q) begin
          state_d = StHeld;
          deb_d   = '0;
        end else if (deb_q == DebLast) begin
          state_d = StIdle;
          deb_d   = '0;
        end else begin
          deb_d = deb_q + CNT_W'(1);
        end
      end
    endcase
  end

`ifdef TOUCH_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RepLast = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_q, rep_d;

  // Counts cycles spent in HELD; a repeat request clears it whether or not it is emitted.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (state_q == StHeld && state_d == StHeld) begin
      if (rep_q == RepLast) begin
        rep_fire = 1'b1;
      end else begin
        rep_d = rep_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  // Repeat period only matters when auto-repeat is built in.
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
  assign rep_fire      = 1'b0;
`endif

  // Gated requests are dropped, never queued.
  assign touch_d   = (fire | rep_fire) & enable & (lock_q == '0);
  assign pressed_d = (state_d == StHeld) || (state_d == StRel);
  assign busy_d    = (lock_q != '0);

  always_comb begin
    lock_d = lock_q;
    if (touch_d) begin
      lock_d = LockLoad;
    end else if (lock_q != '0) begin
      lock_d = lock_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      deb_q     <= '0;
      lock_q    <= '0;
      touch_q   <= 1'b0;
      pressed_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      lock_q    <= lock_d;
      touch_q   <= touch_d;
      pressed_q <= pressed_d;
      busy_q    <= busy_d;
    end
  end

  assign touch   = touch_q;
  assign pressed = pressed_q;
  assign busy    = busy_q;

endmodule
